// File: rtl/decode_pkg.sv
// Shared decode constants: one-hot bit indices, MIPS opcode/funct values, queue entry layout.
// Combinational definitions only; no latency or flow control lives here.
// Consumers: insn_onehot_decode (match tables) and decode_queue (entry storage).
package decode_pkg;

    localparam int CODE_W = 54;

    localparam logic [5:0]
        OP_ADD   = 6'd0,  OP_ADDU  = 6'd1,  OP_SUB   = 6'd2,  OP_SUBU  = 6'd3,
        OP_AND   = 6'd4,  OP_OR    = 6'd5,  OP_XOR   = 6'd6,  OP_NOR   = 6'd7,
        OP_SLT   = 6'd8,  OP_SLTU  = 6'd9,  OP_SLL   = 6'd10, OP_SRL   = 6'd11,
        OP_SRA   = 6'd12, OP_SLLV  = 6'd13, OP_SRLV  = 6'd14, OP_SRAV  = 6'd15,
        OP_JR    = 6'd16, OP_ADDI  = 6'd17, OP_ADDIU = 6'd18, OP_ANDI  = 6'd19,
        OP_ORI   = 6'd20, OP_XORI  = 6'd21, OP_LUI   = 6'd22, OP_LW    = 6'd23,
        OP_SW    = 6'd24, OP_BEQ   = 6'd25, OP_BNE   = 6'd26, OP_SLTI  = 6'd27,
        OP_SLTIU = 6'd28, OP_J     = 6'd29, OP_JAL   = 6'd30, OP_CLZ   = 6'd31,
        OP_DIVU  = 6'd32, OP_DIV   = 6'd33, OP_MUL   = 6'd34, OP_MULTU = 6'd35,
        OP_JALR  = 6'd36, OP_BGEZ  = 6'd37, OP_LH    = 6'd38, OP_LB    = 6'd39,
        OP_LBU   = 6'd40, OP_LHU   = 6'd41, OP_SB    = 6'd42, OP_SH    = 6'd43,
        OP_MFC0  = 6'd44, OP_MTC0  = 6'd45, OP_MFHI  = 6'd46, OP_MTHI  = 6'd47,
        OP_MFLO  = 6'd48, OP_MTLO  = 6'd49, OP_ERET  = 6'd50, OP_SYSCALL = 6'd51,
        OP_TEQ   = 6'd52, OP_BREAK = 6'd53;

    localparam logic [5:0] FIRST_EXT_BIT = 6'd31;

    localparam logic [5:0]
        OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J     = 6'h02, OPC_JAL   = 6'h03,
        OPC_BEQ     = 6'h04, OPC_BNE    = 6'h05, OPC_ADDI  = 6'h08, OPC_ADDIU = 6'h09,
        OPC_SLTI    = 6'h0A, OPC_SLTIU  = 6'h0B, OPC_ANDI  = 6'h0C, OPC_ORI   = 6'h0D,
        OPC_XORI    = 6'h0E, OPC_LUI    = 6'h0F, OPC_COP0  = 6'h10, OPC_SPECIAL2 = 6'h1C,
        OPC_LB      = 6'h20, OPC_LH     = 6'h21, OPC_LW    = 6'h23, OPC_LBU   = 6'h24,
        OPC_LHU     = 6'h25, OPC_SB     = 6'h28, OPC_SH    = 6'h29, OPC_SW    = 6'h2B;

    localparam logic [5:0]
        F_SLL   = 6'h00, F_SRL   = 6'h02, F_SRA   = 6'h03, F_SLLV  = 6'h04,
        F_SRLV  = 6'h06, F_SRAV  = 6'h07, F_JR    = 6'h08, F_JALR  = 6'h09,
        F_SYSCALL = 6'h0C, F_BREAK = 6'h0D, F_MFHI = 6'h10, F_MTHI = 6'h11,
        F_MFLO  = 6'h12, F_MTLO  = 6'h13, F_MULTU = 6'h19, F_DIV   = 6'h1A,
        F_DIVU  = 6'h1B, F_ADD   = 6'h20, F_ADDU  = 6'h21, F_SUB   = 6'h22,
        F_SUBU  = 6'h23, F_AND   = 6'h24, F_OR    = 6'h25, F_XOR   = 6'h26,
        F_NOR   = 6'h27, F_SLT   = 6'h2A, F_SLTU  = 6'h2B, F_TEQ   = 6'h34;

    localparam logic [5:0] F2_MUL = 6'h02, F2_CLZ = 6'h20, F_ERET = 6'h18;

    localparam logic [10:0] MFC0_HI = 11'b01000000000;
    localparam logic [10:0] MTC0_HI = 11'b01000000100;

    // instr[25:0] covers every extracted field; the opcode is fully captured by code
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              illegal;
        logic [25:0]       body;
    } entry_t;

endpackage

// File: rtl/insn_onehot_decode.sv
// Purpose: map a MIPS-32 word to a one-hot op code and an illegal flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is captured.
module insn_onehot_decode
    import decode_pkg::*;
#(
    parameter bit EXT_EN = 1'b1
) (
    input  logic [31:0]       instr,
    output logic [CODE_W-1:0] code,
    output logic              illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [5:0] idx;
    logic       hit;
    logic       unused_mid;

    assign opcode     = instr[31:26];
    assign funct      = instr[5:0];
    assign unused_mid = ^instr[20:6];

    always_comb begin
        hit = 1'b1;
        idx = '0;
        case (opcode)
            OPC_SPECIAL: begin
                case (funct)
                    F_ADD:     idx = OP_ADD;
                    F_ADDU:    idx = OP_ADDU;
                    F_SUB:     idx = OP_SUB;
                    F_SUBU:    idx = OP_SUBU;
                    F_AND:     idx = OP_AND;
                    F_OR:      idx = OP_OR;
                    F_XOR:     idx = OP_XOR;
                    F_NOR:     idx = OP_NOR;
                    F_SLT:     idx = OP_SLT;
                    F_SLTU:    idx = OP_SLTU;
                    F_SLL:     idx = OP_SLL;
                    F_SRL:     idx = OP_SRL;
                    F_SRA:     idx = OP_SRA;
                    F_SLLV:    idx = OP_SLLV;
                    F_SRLV:    idx = OP_SRLV;
                    F_SRAV:    idx = OP_SRAV;
                    F_JR:      idx = OP_JR;
                    F_JALR:    idx = OP_JALR;
                    F_DIVU:    idx = OP_DIVU;
                    F_DIV:     idx = OP_DIV;
                    F_MULTU:   idx = OP_MULTU;
                    F_MFHI:    idx = OP_MFHI;
                    F_MTHI:    idx = OP_MTHI;
                    F_MFLO:    idx = OP_MFLO;
                    F_MTLO:    idx = OP_MTLO;
                    F_SYSCALL: idx = OP_SYSCALL;
                    F_TEQ:     idx = OP_TEQ;
                    F_BREAK:   idx = OP_BREAK;
                    default:   hit = 1'b0;
                endcase
            end
            OPC_SPECIAL2: begin
                case (funct)
                    F2_CLZ:  idx = OP_CLZ;
                    F2_MUL:  idx = OP_MUL;
                    default: hit = 1'b0;
                endcase
            end
            // mfc0/mtc0 own their rs field, so they must win before the eret funct check
            OPC_COP0: begin
                if (instr[31:21] == MFC0_HI)
                    idx = OP_MFC0;
                else if (instr[31:21] == MTC0_HI)
                    idx = OP_MTC0;
                else if (instr[25] && funct == F_ERET)
                    idx = OP_ERET;
                else
                    hit = 1'b0;
            end
            OPC_REGIMM: idx = OP_BGEZ;
            OPC_ADDI:   idx = OP_ADDI;
            OPC_ADDIU:  idx = OP_ADDIU;
            OPC_ANDI:   idx = OP_ANDI;
            OPC_ORI:    idx = OP_ORI;
            OPC_XORI:   idx = OP_XORI;
            OPC_LUI:    idx = OP_LUI;
            OPC_LW:     idx = OP_LW;
            OPC_SW:     idx = OP_SW;
            OPC_BEQ:    idx = OP_BEQ;
            OPC_BNE:    idx = OP_BNE;
            OPC_SLTI:   idx = OP_SLTI;
            OPC_SLTIU:  idx = OP_SLTIU;
            OPC_J:      idx = OP_J;
            OPC_JAL:    idx = OP_JAL;
            OPC_LH:     idx = OP_LH;
            OPC_LB:     idx = OP_LB;
            OPC_LBU:    idx = OP_LBU;
            OPC_LHU:    idx = OP_LHU;
            OPC_SB:     idx = OP_SB;
            OPC_SH:     idx = OP_SH;
            default:    hit = 1'b0;
        endcase
    end

    always_comb begin
        illegal = !hit || (!EXT_EN && (idx >= FIRST_EXT_BIT));
        code    = '0;
        if (!illegal)
            code = {{(CODE_W-1){1'b0}}, 1'b1} << idx;
    end

endmodule

// File: rtl/decode_queue.sv
// Purpose: decode fetched instructions and buffer them for the control unit.
// Latency: 1 cycle from push to head when empty.
// Backpressure: in_ready = not full from registered count; flush discards all entries.
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int PC_W   = 32,
    parameter bit EXT_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CODE_W-1:0]      out_code,
    output logic                   out_illegal,
    output logic [PC_W-1:0]        out_pc,
    output logic [4:0]             out_rs,
    output logic [4:0]             out_rt,
    output logic [4:0]             out_rd,
    output logic [4:0]             out_shamt,
    output logic [15:0]            out_imm,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [CODE_W-1:0] dec_code;
    logic              dec_illegal;
    entry_t            mem    [DEPTH];
    logic [PC_W-1:0]   pc_mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    entry_t            head;

    insn_onehot_decode #(.EXT_EN(EXT_EN)) u_dec (
        .instr   (in_instr),
        .code    (dec_code),
        .illegal (dec_illegal)
    );

    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: everything read from it is masked while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]    <= '{code: dec_code, illegal: dec_illegal, body: in_instr[25:0]};
            pc_mem[wr_ptr] <= in_pc;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        out_code    = '0;
        out_illegal = 1'b0;
        out_pc      = '0;
        out_rs      = '0;
        out_rt      = '0;
        out_rd      = '0;
        out_shamt   = '0;
        out_imm     = '0;
        if (out_valid) begin
            out_code    = head.code;
            out_illegal = head.illegal;
            out_pc      = pc_mem[rd_ptr];
            out_rs      = head.body[25:21];
            out_rt      = head.body[20:16];
            out_rd      = head.body[15:11];
            out_shamt   = head.body[10:6];
            out_imm     = head.body[15:0];
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed table, hand-written corner sequences, randomized
// traffic against a mask/match instruction table and a queue model.
module tb_decode_queue;

    localparam int DEPTH = 2;

    logic        clk, rst_n, flush;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_pc;
    logic [53:0] out_code;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [15:0] out_imm;
    logic [1:0]  count;

    logic        x_in_valid, x_in_ready, x_out_valid, x_out_ready, x_out_illegal;
    logic [31:0] x_out_pc;
    logic [53:0] x_out_code;
    logic [4:0]  x_out_rs, x_out_rt, x_out_rd, x_out_shamt;
    logic [15:0] x_out_imm;
    logic [1:0]  x_count;

    decode_queue #(.DEPTH(DEPTH), .PC_W(32), .EXT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_illegal(out_illegal), .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt),
        .out_rd(out_rd), .out_shamt(out_shamt), .out_imm(out_imm), .count(count)
    );

    decode_queue #(.DEPTH(DEPTH), .PC_W(32), .EXT_EN(1'b0)) dut_x (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(x_in_valid), .in_ready(x_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(x_out_valid), .out_ready(x_out_ready), .out_code(x_out_code),
        .out_illegal(x_out_illegal), .out_pc(x_out_pc), .out_rs(x_out_rs), .out_rt(x_out_rt),
        .out_rd(x_out_rd), .out_shamt(x_out_shamt), .out_imm(x_out_imm), .count(x_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: each instruction is a (mask, value) pattern over the raw word
    logic [31:0] pat_mask [54];
    logic [31:0] pat_val  [54];

    task automatic set_raw(input int k, input logic [31:0] m, input logic [31:0] v);
        pat_mask[k] = m;
        pat_val[k]  = v;
    endtask
    task automatic set_r(input int k, input logic [5:0] f);
        set_raw(k, 32'hFC00003F, {26'd0, f});
    endtask
    task automatic set_i(input int k, input logic [5:0] op);
        set_raw(k, 32'hFC000000, {op, 26'd0});
    endtask

    task automatic init_patterns();
        set_r(0, 6'h20);  set_r(1, 6'h21);  set_r(2, 6'h22);  set_r(3, 6'h23);
        set_r(4, 6'h24);  set_r(5, 6'h25);  set_r(6, 6'h26);  set_r(7, 6'h27);
        set_r(8, 6'h2A);  set_r(9, 6'h2B);  set_r(10, 6'h00); set_r(11, 6'h02);
        set_r(12, 6'h03); set_r(13, 6'h04); set_r(14, 6'h06); set_r(15, 6'h07);
        set_r(16, 6'h08);
        set_i(17, 6'h08); set_i(18, 6'h09); set_i(19, 6'h0C); set_i(20, 6'h0D);
        set_i(21, 6'h0E); set_i(22, 6'h0F); set_i(23, 6'h23); set_i(24, 6'h2B);
        set_i(25, 6'h04); set_i(26, 6'h05); set_i(27, 6'h0A); set_i(28, 6'h0B);
        set_i(29, 6'h02); set_i(30, 6'h03);
        set_raw(31, 32'hFC00003F, 32'h70000020);
        set_r(32, 6'h1B); set_r(33, 6'h1A);
        set_raw(34, 32'hFC00003F, 32'h70000002);
        set_r(35, 6'h19); set_r(36, 6'h09); set_i(37, 6'h01);
        set_i(38, 6'h21); set_i(39, 6'h20); set_i(40, 6'h24); set_i(41, 6'h25);
        set_i(42, 6'h28); set_i(43, 6'h29);
        set_raw(44, 32'hFFE00000, 32'h40000000);
        set_raw(45, 32'hFFE00000, 32'h40800000);
        set_r(46, 6'h10); set_r(47, 6'h11); set_r(48, 6'h12); set_r(49, 6'h13);
        set_raw(50, 32'hFE00003F, 32'h42000018);
        set_r(51, 6'h0C); set_r(52, 6'h34); set_r(53, 6'h0D);
    endtask

    function automatic logic [53:0] onehot(input int idx);
        logic [53:0] c;
        c = '0;
        if (idx >= 0) c[idx] = 1'b1;
        return c;
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, input bit ext,
                                       output logic [53:0] code, output logic ill);
        int hit;
        hit = -1;
        for (int k = 0; k < 54; k++)
            if ((ins & pat_mask[k]) == pat_val[k]) hit = k;
        ill  = (hit < 0) || (!ext && hit >= 31);
        code = ill ? 54'd0 : onehot(hit);
    endfunction

    typedef struct {
        logic [31:0] instr;
        int          idx_ext;
        int          idx_noext;
    } vec_t;
    vec_t vecs [15];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;
    item_t mq [$];

    initial begin
        logic [53:0] ecode;
        logic        eill;
        logic [31:0] ins;
        int          k;

        init_patterns();
        vecs[0]  = '{32'h00851020, 0, 0};     // add
        vecs[1]  = '{32'h00000000, 10, 10};   // sll
        vecs[2]  = '{32'h40026000, 44, -1};   // mfc0
        vecs[3]  = '{32'h40826000, 45, -1};   // mtc0
        vecs[4]  = '{32'h42000018, 50, -1};   // eret
        vecs[5]  = '{32'h70852020, 31, -1};   // clz
        vecs[6]  = '{32'hFC000000, -1, -1};
        vecs[7]  = '{32'h8C850004, 23, 23};   // lw
        vecs[8]  = '{32'h03E00008, 16, 16};   // jr
        vecs[9]  = '{32'h0000000C, 51, -1};   // syscall
        vecs[10] = '{32'h0C000010, 30, 30};   // jal
        vecs[11] = '{32'h40200018, -1, -1};   // cop0 eret funct without bit 25
        vecs[12] = '{32'h0000003F, -1, -1};
        vecs[13] = '{32'h04010005, 37, -1};   // bgez
        vecs[14] = '{32'h70A40002, 34, -1};   // mul

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; x_in_valid = 1'b0;
        out_ready = 1'b0; x_out_ready = 1'b1; in_instr = '0; in_pc = '0;
        #3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_code", out_code, 0);
        #9 rst_n = 1'b1;

        // add $2,$4,$5 with hand-derived fields
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00851020; in_pc = 32'h400; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_code", out_code, 54'd1);
        chk("add_rs", out_rs, 4);
        chk("add_rt", out_rt, 5);
        chk("add_rd", out_rd, 2);
        chk("add_illegal", out_illegal, 0);
        chk("add_pc", out_pc, 32'h400);
        @(negedge clk);
        chk("add_drained", out_valid, 0);
        chk("add_drained_code", out_code, 0);

        // Directed table on both EXT_EN variants
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; x_in_valid = 1'b1; out_ready = 1'b1;
            in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(i * 4);
            @(negedge clk);
            in_valid = 1'b0; x_in_valid = 1'b0;
            ins = vecs[i].instr;
            chk($sformatf("tab%0d_valid", i), out_valid, 1);
            chk($sformatf("tab%0d_code", i), out_code, onehot(vecs[i].idx_ext));
            chk($sformatf("tab%0d_ill", i), out_illegal, vecs[i].idx_ext < 0);
            chk($sformatf("tab%0d_x_code", i), x_out_code, onehot(vecs[i].idx_noext));
            chk($sformatf("tab%0d_x_ill", i), x_out_illegal, vecs[i].idx_noext < 0);
            chk($sformatf("tab%0d_pc", i), out_pc, 32'h1000 + 32'(i * 4));
            chk($sformatf("tab%0d_fields", i), {out_rs, out_rt, out_rd, out_shamt, out_imm},
                {ins[25:21], ins[20:16], ins[15:11], ins[10:6], ins[15:0]});
            @(negedge clk);
            chk($sformatf("tab%0d_empty", i), out_valid | x_out_valid, 0);
        end

        // Fill to DEPTH under backpressure, try an extra push, then drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00851020; in_pc = 32'h100;
        @(negedge clk);
        in_instr = 32'h8C850004; in_pc = 32'h104;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, DEPTH);
        in_instr = 32'h00000000; in_pc = 32'h108;
        @(negedge clk);
        chk("full_no_accept", count, DEPTH);
        chk("full_head_pc", out_pc, 32'h100);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("drain1_pc", out_pc, 32'h104);
        chk("drain1_code", out_code, onehot(23));
        chk("drain1_count", count, 1);
        @(negedge clk);
        chk("drain2_empty", out_valid, 0);

        // Flush with competing push and pop on a full queue
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00851020; in_pc = 32'h200;
        @(negedge clk);
        in_pc = 32'h204;
        @(negedge clk);
        chk("preflush_count", count, DEPTH);
        flush = 1'b1; out_ready = 1'b1; in_pc = 32'h208;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        @(negedge clk);
        chk("flush_nothing_accepted", count, 0);

        // Asynchronous reset between clock edges
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300;
        @(negedge clk);
        in_pc = 32'h304;
        @(negedge clk);
        in_valid = 1'b0;
        chk("prereset_count", count, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_pc", out_pc, 0);
        #4 rst_n = 1'b1;

        // Randomized traffic against the queue model
        mq.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            chk("rnd_count", count, mq.size());
            chk("rnd_valid", out_valid, mq.size() != 0);
            chk("rnd_in_ready", in_ready, mq.size() < DEPTH);
            if (mq.size() != 0) begin
                ins = mq[0].instr;
                ref_decode(ins, 1'b1, ecode, eill);
                chk("rnd_code", out_code, ecode);
                chk("rnd_ill", out_illegal, eill);
                chk("rnd_pc", out_pc, mq[0].pc);
                chk("rnd_fields", {out_rs, out_rt, out_rd, out_shamt, out_imm},
                    {ins[25:21], ins[20:16], ins[15:11], ins[10:6], ins[15:0]});
            end else begin
                chk("rnd_masked", {out_code, out_illegal, out_pc, out_imm, out_rs}, 0);
            end
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_pc     = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                in_instr = $urandom;
            end else begin
                k = $urandom_range(0, 53);
                in_instr = ($urandom & ~pat_mask[k]) | pat_val[k];
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (in_valid && mq.size() < DEPTH) begin
                    if (out_ready && mq.size() != 0) void'(mq.pop_front());
                    mq.push_back('{in_instr, in_pc});
                end else if (out_ready && mq.size() != 0) begin
                    void'(mq.pop_front());
                end
            end
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, parametrised instruction-decode stage between fetch and the control unit.
- Translates each accepted MIPS-32 instruction into a 54-bit one-hot operation code plus extracted register/immediate fields.
- Flags illegal or disabled encodings and buffers decoded entries in a small FIFO with valid/ready handshakes on both sides.
- Adds flush, backpressure and an extension-disable mode.

Parameters:
DEPTH, 2, number of decoded entries buffered; power of two, >= 2
PC_W, 32, width of the PC carried with each instruction
EXT_EN, 1, 1 = all 54 instructions legal; 0 = one-hot bits 31..53 are treated as illegal

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all buffered entries (branch/exception redirect)
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept
in_instr  in  32  raw instruction word
in_pc  in  PC_W  PC of in_instr
out_valid  out  1  head entry valid
out_ready  in  1  control unit consumes head
out_code  out  54  one-hot operation code of head entry
out_illegal  out  1  head entry is reserved/disabled instruction
out_pc  out  PC_W  PC of head entry
out_rs, out_rt, out_rd, out_shamt  out  5 each  instr[25:21], [20:16], [15:11], [10:6]
out_imm  out  16  instr[15:0]
count  out  clog2(DEPTH)+1  number of buffered entries

Behaviour:
- Reset (rst_n=0, async): count=0, pointers=0, out_valid=0. Output data is all-zero while out_valid=0 (masked, not stale).
- One-hot map (bit index: instruction):
  - 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu
  - 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav, 16 jr
  - 17 addi, 18 addiu, 19 andi, 20 ori, 21 xori, 22 lui, 23 lw, 24 sw, 25 beq, 26 bne, 27 slti, 28 sltiu, 29 j, 30 jal
  - 31 clz, 32 divu, 33 div, 34 mul, 35 multu, 36 jalr, 37 bgez
  - 38 lh, 39 lb, 40 lbu, 41 lhu, 42 sb, 43 sh
  - 44 mfc0, 45 mtc0, 46 mfhi, 47 mthi, 48 mflo, 49 mtlo, 50 eret, 51 syscall, 52 teq, 53 break
- Match rules:
  - R-type and special ops match {opcode, funct}. I/J-type match opcode only.
  - mfc0 is instr[31:21]=01000000000; mtc0 is instr[31:21]=01000000100. Both are checked before the eret/funct match.
  - eret additionally requires instr[25]=1.
  - Exactly one bit is set for a legal instruction. 0x00000000 decodes as sll (legal).
- Illegal: no match, or EXT_EN=0 and the matched bit is >=31. The stored code is all-zero and illegal=1. An illegal entry still occupies a slot and flows normally.
- Push: in_valid & in_ready at a rising edge stores the decode of in_instr plus the fields and PC.
- in_ready = (count < DEPTH). It is registered-state based, with no combinational path from out_ready.
- Pop: out_valid & out_ready at the edge advances the head.
- out_valid = (count != 0).
- Latency: an instruction pushed at edge N is visible at the head after edge N (1 cycle) when the queue was empty.
- Simultaneous push and pop: count unchanged, both pointers advance. Allowed even when full? No: when full, in_ready=0, so a push is impossible that cycle.
- Pointers wrap modulo DEPTH.
- flush (synchronous) has priority over push and pop: the next cycle has count=0 and out_valid=0, and any handshake in the flush cycle is ignored.
- Reset mid-operation clears immediately regardless of pending handshakes.

Decomposition:
- Shared package decode_pkg: one-hot bit-index constants (OP_ADD=0 ... OP_BREAK=53), CODE_W=54, the opcode/funct localparams, and FIRST_EXT_BIT=31.
- Sub-module insn_onehot_decode: purely combinational, instr in, code and illegal out, with parameter EXT_EN.
- decode_queue instantiates insn_onehot_decode plus the FIFO storage and control.

Test Plan:
- Reset then push 0x00851020 (add $2,$4,$5) with out_ready=1 -> next cycle out_valid=1, out_code bit0 only, rs=4, rt=5, rd=2, illegal=0; the following cycle out_valid=0.
- Push 0x40026000 (mfc0) and 0x40826000 (mtc0) -> codes with bit44 and bit45 respectively; push 0x42000018 -> bit50.
- EXT_EN=0, push 0x70852020 (clz) -> out_code=0, out_illegal=1; push 0xFC000000 with EXT_EN=1 -> illegal=1.
- Hold out_ready=0, push DEPTH instructions -> in_ready=0 and count=DEPTH; a further in_valid is not accepted; release out_ready -> entries drain in order with correct PCs.
- Full queue, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, nothing accepted.
- Assert rst_n=0 asynchronously between edges with 2 entries buffered -> out_valid and count drop to 0 immediately, without waiting for a clock edge.
